// File: rtl/btn_arb_pkg.sv
// Shared types and constants for the button command arbiter.
package btn_arb_pkg;

  typedef enum logic [1:0] {IDLE, VALID, HOLDOFF} arb_state_t;

  localparam int unsigned DROP_CNT_W = 8;

endpackage

// File: rtl/btn_cmd_arbiter_if.sv
// Command handshake between the button arbiter and the plotter command decoder.
interface btn_cmd_arbiter_if #(
  parameter int unsigned ID_W = 2
);

  logic            cmd_valid;
  logic [ID_W-1:0] cmd_id;
  logic            cmd_ready;

  modport master (output cmd_valid, output cmd_id, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_id, output cmd_ready);

endinterface

// File: rtl/btn_cmd_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests to start at ptr,
// take the lowest set bit, then map the offset back to a button index.
module rr_pick #(
  parameter int unsigned NUM_BTN = 4,
  parameter int unsigned ID_W    = $clog2(NUM_BTN)
) (
  input  logic [NUM_BTN-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    gnt_id,
  output logic               gnt_any
);

  localparam int unsigned SUM_W = ID_W + 1;

  logic [NUM_BTN-1:0] rot;
  logic [SUM_W-1:0]   idx;
  logic [ID_W-1:0]    off;
  logic [SUM_W-1:0]   sum;

  always_comb begin
    rot = '0;
    idx = '0;
    off = '0;
    sum = '0;
    // Explicit wrap compare keeps non-power-of-two counts correct.
    for (int i = 0; i < NUM_BTN; i++) begin
      idx = {1'b0, ptr} + SUM_W'(i);
      if (idx >= SUM_W'(NUM_BTN)) idx = idx - SUM_W'(NUM_BTN);
      rot[i] = req[idx[ID_W-1:0]];
    end
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (rot[i]) off = ID_W'(i);
    end
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= SUM_W'(NUM_BTN)) sum = sum - SUM_W'(NUM_BTN);
    gnt_id  = sum[ID_W-1:0];
    gnt_any = |req;
  end

endmodule

// File: rtl/btn_cmd_arbiter.sv
// Queues debounced button presses and issues them round-robin as commands
// with a holdoff gap. Define BTN_ARB_DROP_CNT_EN to count coalesced presses.
module btn_cmd_arbiter
  import btn_arb_pkg::*;
#(
  parameter int unsigned NUM_BTN     = 4,
  parameter int unsigned ID_W        = $clog2(NUM_BTN),
  parameter int unsigned HOLDOFF_CYC = 50000,
  parameter int unsigned HOLDOFF_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_BTN-1:0]    btn_pulse,
  input  logic [NUM_BTN-1:0]    btn_mask,
  btn_cmd_arbiter_if.master     cmd,
  output logic [NUM_BTN-1:0]    pending,
  output logic                  busy,
  output logic [DROP_CNT_W-1:0] drop_cnt
);

  arb_state_t           state;
  logic [ID_W-1:0]      rr_ptr;
  logic [HOLDOFF_W-1:0] hold_cnt;
  logic [ID_W-1:0]      win_id;
  logic                 win_any;
  logic [NUM_BTN-1:0]   gnt_vec_c;
  logic [NUM_BTN-1:0]   live_c;

  rr_pick #(
    .NUM_BTN (NUM_BTN),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .req     (pending),
    .ptr     (rr_ptr),
    .gnt_id  (win_id),
    .gnt_any (win_any)
  );

  // One-hot grant this edge and unmasked presses this edge.
  always_comb begin
    gnt_vec_c = '0;
    if (state == IDLE && win_any) gnt_vec_c[win_id] = 1'b1;
    live_c = btn_pulse & ~btn_mask;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pending       <= '0;
      rr_ptr        <= '0;
      cmd.cmd_valid <= 1'b0;
      cmd.cmd_id    <= '0;
      hold_cnt      <= '0;
      busy          <= 1'b0;
    end else begin
      // A new press on the granted bit survives the grant clear.
      pending <= (pending & ~gnt_vec_c & ~btn_mask) | live_c;
      case (state)
        IDLE: begin
          if (win_any) begin
            cmd.cmd_id    <= win_id;
            rr_ptr        <= (win_id == ID_W'(NUM_BTN - 1)) ? '0 : win_id + ID_W'(1);
            cmd.cmd_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= VALID;
          end
        end
        VALID: begin
          if (cmd.cmd_ready) begin
            cmd.cmd_valid <= 1'b0;
            if (HOLDOFF_CYC == 0) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              hold_cnt <= HOLDOFF_W'(HOLDOFF_CYC - 1);
              state    <= HOLDOFF;
            end
          end
        end
        HOLDOFF: begin
          if (hold_cnt == '0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - HOLDOFF_W'(1);
          end
        end
        default: begin
          cmd.cmd_valid <= 1'b0;
          busy          <= 1'b0;
          state         <= IDLE;
        end
      endcase
    end
  end

`ifdef BTN_ARB_DROP_CNT_EN
  logic drop_hit_c;

  assign drop_hit_c = |(live_c & pending & ~gnt_vec_c);

  // Saturating count of edges that coalesced at least one press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_hit_c && drop_cnt != '1) begin
      drop_cnt <= drop_cnt + DROP_CNT_W'(1);
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_btn_cmd_arbiter.sv
// Scoreboard bench for btn_cmd_arbiter: stimulus queues expected ids, a
// negedge monitor checks every accepted command against the queue.
module tb_btn_cmd_arbiter;
  import btn_arb_pkg::*;

  localparam int unsigned NUM_BTN = 4;
  localparam int unsigned ID_W    = 2;
  localparam int unsigned HOLD    = 4;
`ifdef BTN_ARB_DROP_CNT_EN
  localparam int unsigned DROP_EXP = 2;
`else
  localparam int unsigned DROP_EXP = 0;
`endif

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NUM_BTN-1:0]    btn_pulse = '0;
  logic [NUM_BTN-1:0]    btn_mask  = '0;
  logic [NUM_BTN-1:0]    pending;
  logic                  busy;
  logic [DROP_CNT_W-1:0] drop_cnt;

  btn_cmd_arbiter_if #(.ID_W(ID_W)) cmd_if ();

  btn_cmd_arbiter #(
    .NUM_BTN     (NUM_BTN),
    .ID_W        (ID_W),
    .HOLDOFF_CYC (HOLD),
    .HOLDOFF_W   (16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_pulse (btn_pulse),
    .btn_mask  (btn_mask),
    .cmd       (cmd_if),
    .pending   (pending),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input logic [NUM_BTN-1:0] v);
    btn_pulse = v;
    tick();
    btn_pulse = '0;
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((busy || cmd_if.cmd_valid || pending != '0 || exp_q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk(name, 32'(n < 300), 32'd1);
  endtask

  // Monitor: compare each accepted command and check id stability under stall.
  initial begin : monitor
    logic            held;
    logic [ID_W-1:0] held_id;
    held    = 1'b0;
    held_id = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("valid_held", 32'(cmd_if.cmd_valid), 32'd1);
          chk("id_stable", 32'(cmd_if.cmd_id), 32'(held_id));
        end
        if (cmd_if.cmd_valid && cmd_if.cmd_ready) begin
          if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_cmd: got id %0d expected none", cmd_if.cmd_id);
          end else begin
            chk("cmd_id", 32'(cmd_if.cmd_id), 32'(exp_q.pop_front()));
          end
          held = 1'b0;
        end else begin
          held    = cmd_if.cmd_valid;
          held_id = cmd_if.cmd_id;
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    cmd_if.cmd_ready = 1'b1;
    tick(2);
    chk("rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("rst_id", 32'(cmd_if.cmd_id), 32'd0);
    chk("rst_pending", 32'(pending), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Single press with holdoff.
    exp_q.push_back(2);
    pulse(4'b0100);
    chk("t1_pending_set", 32'(pending), 32'h4);
    chk("t1_valid_early", 32'(cmd_if.cmd_valid), 32'd0);
    tick();
    chk("t1_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("t1_id", 32'(cmd_if.cmd_id), 32'd2);
    chk("t1_pending_clr", 32'(pending), 32'd0);
    tick();
    for (int i = 0; i < int'(HOLD); i++) begin
      chk("t1_hold_busy", 32'(busy), 32'd1);
      chk("t1_hold_novalid", 32'(cmd_if.cmd_valid), 32'd0);
      tick();
    end
    chk("t1_idle", 32'(busy), 32'd0);

    // Round-robin from a fresh pointer; the trailing pair proves the pointer wrapped to 0.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(3);
    pulse(4'b1111);
    wait_drain("t2_rr_drain");
    exp_q.push_back(0); exp_q.push_back(3);
    pulse(4'b1001);
    wait_drain("t2_ptr_drain");

    // Backpressure with a request queued behind the stalled command.
    cmd_if.cmd_ready = 1'b0;
    exp_q.push_back(1); exp_q.push_back(3);
    pulse(4'b0010);
    tick();
    pulse(4'b1000);
    tick(20);
    chk("t3_valid", 32'(cmd_if.cmd_valid), 32'd1);
    chk("t3_id", 32'(cmd_if.cmd_id), 32'd1);
    chk("t3_pending", 32'(pending), 32'h8);
    cmd_if.cmd_ready = 1'b1;
    wait_drain("t3_drain");

    // Repeated presses of a pending button coalesce.
    cmd_if.cmd_ready = 1'b0;
    exp_q.push_back(1); exp_q.push_back(0);
    pulse(4'b0010);
    tick();
    pulse(4'b0001);
    tick();
    pulse(4'b0001);
    tick();
    pulse(4'b0001);
    tick();
    chk("t4_drop", 32'(drop_cnt), 32'(DROP_EXP));
    chk("t4_pending", 32'(pending), 32'h1);
    cmd_if.cmd_ready = 1'b1;
    wait_drain("t4_drain");
    chk("t4_drop_after", 32'(drop_cnt), 32'(DROP_EXP));

    // Masking clears a pending bit but never withdraws the presented command.
    cmd_if.cmd_ready = 1'b0;
    exp_q.push_back(1);
    pulse(4'b0010);
    tick();
    pulse(4'b0100);
    chk("t5_pending_set", 32'(pending), 32'h4);
    btn_mask = 4'b0110;
    tick();
    chk("t5_pending_masked", 32'(pending), 32'd0);
    chk("t5_valid_kept", 32'(cmd_if.cmd_valid), 32'd1);
    tick(3);
    chk("t5_id_kept", 32'(cmd_if.cmd_id), 32'd1);
    cmd_if.cmd_ready = 1'b1;
    tick();
    btn_mask = '0;
    wait_drain("t5_drain");
    tick(10);
    chk("t5_no_grant", 32'(cmd_if.cmd_valid), 32'd0);

    // Asynchronous reset in the middle of holdoff.
    exp_q.push_back(0);
    pulse(4'b0001);
    tick(2);
    pulse(4'b0110);
    chk("t6_pending", 32'(pending), 32'h6);
    chk("t6_busy", 32'(busy), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("t6_rst_pending", 32'(pending), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_drop", 32'(drop_cnt), 32'd0);
    tick();
    rst = 1'b0;
    tick(15);
    chk("t6_quiet_valid", 32'(cmd_if.cmd_valid), 32'd0);
    chk("t6_quiet_busy", 32'(busy), 32'd0);
    chk("t6_quiet_pending", 32'(pending), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/btn_cmd_arbiter.md
Name: btn_cmd_arbiter

Overview:
- Collects single-cycle debounced press pulses from NUM_BTN front-panel buttons and queues one pending request per button.
- Arbitrates pending requests round-robin and issues one command at a time to the plotter control FSM over a valid/ready handshake.
- Enforces a holdoff gap after each accepted command so back-to-back presses cannot flood the motion sequencer.
- Sits between the bank of per-button debouncers and the plotter command decoder.

Parameters:
- NUM_BTN, 4, number of button request inputs (2..16).
- ID_W, $clog2(NUM_BTN), width of cmd_id.
- HOLDOFF_CYC, 50000, idle cycles enforced after each accepted command; 0 disables holdoff.
- HOLDOFF_W, 16, holdoff counter width; must satisfy HOLDOFF_CYC < 2**HOLDOFF_W.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- btn_pulse, input, NUM_BTN, one-cycle press pulses from the debouncers.
- btn_mask, input, NUM_BTN, 1 = ignore that button.
- cmd_valid, output, 1, a command is presented.
- cmd_id, output, ID_W, index of the granted button; stable while cmd_valid=1.
- cmd_ready, input, 1, consumer accepts when cmd_valid & cmd_ready.
- pending, output, NUM_BTN, registered pending-request vector.
- busy, output, 1, high when the state is not IDLE.
- drop_cnt, output, 8, count of coalesced presses; tied to 0 without the optional feature.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - pending=0, rr_ptr=0, cmd_valid=0, cmd_id=0, holdoff counter=0, drop_cnt=0.
  - busy=0.
- Pending set/clear:
  - On each edge, pending[i] is set if btn_pulse[i] & ~btn_mask[i].
  - pending[i] is cleared if bit i is granted this edge, or if btn_mask[i]=1.
  - A same-edge grant and new pulse on the same bit leave pending[i]=1 (the new press is queued).
  - A pulse on a bit that is already pending and not being granted is coalesced and counted as a drop.
- FSM, three states:
  - IDLE: if |pending, pick the winner as the first set bit scanning upward from rr_ptr with wrap.
    - Load cmd_id with the winner.
    - Clear pending[winner].
    - Set rr_ptr to winner+1, wrapping NUM_BTN-1 to 0.
    - Go to VALID.
    - If pending=0, stay in IDLE.
  - VALID: cmd_valid=1 and cmd_id is held constant.
    - On cmd_ready=1: if HOLDOFF_CYC=0 go to IDLE, else load the counter with HOLDOFF_CYC-1 and go to HOLDOFF.
    - cmd_ready=0: stay in VALID indefinitely; there is no timeout.
  - HOLDOFF: cmd_valid=0; decrement the counter each cycle and go to IDLE when it reaches 0.
    - Exactly HOLDOFF_CYC cycles are spent in HOLDOFF.
- Latency:
  - A pulse sampled at edge k sets pending after edge k.
  - With the FSM in IDLE, the grant loads at edge k+1 and cmd_valid is high from edge k+1.
  - Minimum command-to-command spacing is 1 (VALID) + HOLDOFF_CYC + 1 (IDLE) cycles.
- Arbitration fairness: with all bits continuously pending, grants rotate 0,1,2,…,NUM_BTN-1,0.
- Masking:
  - Asserting btn_mask[i] during VALID does not withdraw the presented command.
  - It only clears or blocks pending[i].
- Requests arriving during VALID or HOLDOFF accumulate in pending.
- Reset asserted mid-VALID drops the command immediately (cmd_valid=0 asynchronously).
- Arithmetic: rr_ptr is ID_W bits. When NUM_BTN is not a power of two, the wrap is an explicit compare, not a natural overflow.

Optional Feature:
- Macro: BTN_ARB_DROP_CNT_EN.
- Defined:
  - drop_cnt is an 8-bit saturating counter (holds at 255).
  - It increments once per edge on which at least one coalesced press occurs, i.e. any bit with btn_pulse[i] & ~btn_mask[i] & pending[i] & not granted this edge.
  - Reset clears it to 0.
- Undefined: drop_cnt is constant 0, no counter flops are inferred, and all other behaviour is identical.

Decomposition:
- Package btn_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, VALID, HOLDOFF} arb_state_t.
  - localparam DROP_CNT_W = 8.
- Sub-module rr_pick is combinational.
  - Inputs: req[NUM_BTN], ptr[ID_W].
  - Outputs: gnt_id[ID_W], gnt_any.
  - Implemented as a rotate-priority-encode-unrotate.
  - It is instanced once.
- The FSM, pending register, holdoff counter and drop counter remain in btn_cmd_arbiter.

Test Plan:
- Single press, HOLDOFF_CYC=4: pulse bit 2, cmd_ready=1 → cmd_valid high 2 edges after the pulse with cmd_id=2 for 1 cycle, then busy=1 for 4 cycles, then IDLE; pending=0.
- Round-robin: pulse all 4 bits together, cmd_ready=1, HOLDOFF_CYC=0 → cmd_id sequence 0,1,2,3, each separated by one IDLE cycle; rr_ptr ends at 0.
- Backpressure: cmd_ready=0 for 20 cycles while bit 1 is presented and bit 3 is pulsed → cmd_id stays 1, pending=4'b1000; after cmd_ready the next grant is 3.
- Coalesce/drop (macro on): pulse bit 0 three times while it is pending behind a stalled command → one grant for bit 0, drop_cnt=2; macro off → drop_cnt=0.
- Mask: bit 2 pending, assert btn_mask[2] → pending[2] clears next edge and no grant is issued. Masking the presented id during VALID keeps cmd_valid=1 until accepted.
- Async reset mid-HOLDOFF with pending=4'b0110 → all outputs 0 immediately; after release, no command issues without new pulses.
